// File: rtl/aes_subbytes_lanes.sv
// AddRoundKey + SubBytes over a 128-bit AES state, LANES bytes per cycle,
// with run-time forward/inverse selection and a level-held start/finish handshake.
module aes_subbytes_lanes #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         finish,
  output logic         busy,
  output logic [127:0] out
);

  localparam int C     = 16 / LANES;
  localparam int CNT_W = (C > 1) ? $clog2(C) : 1;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_subbytes_lanes: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       data_q, data_d;
  logic [127:0]       key_q, key_d;
  logic               mode_q, mode_d;
  logic [127:0]       out_q, out_d;
  logic               finish_q, finish_d;
  logic               busy_q, busy_d;
  logic [3:0]         base;
  logic [7:0]         lane_out [LANES];

  function automatic logic [7:0] byte_at(input logic [127:0] v, input int idx);
    return v[8*idx +: 8];
  endfunction

  assign base = 4'(int'(cnt_q) * LANES);

  // The lanes read the working copy in place; the key is folded in before or after the lookup by mode.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_out[l] = 8'h00;
      if (INV_EN != 0 && mode_q)
        lane_out[l] = INV_SBOX[byte_at(data_q, int'(base) + l)] ^ byte_at(key_q, int'(base) + l);
      else
        lane_out[l] = SBOX[byte_at(data_q, int'(base) + l) ^ byte_at(key_q, int'(base) + l)];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    key_d    = key_q;
    mode_d   = mode_q;
    out_d    = out_q;
    finish_d = finish_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = in;
          key_d   = key;
          mode_d  = (INV_EN != 0) ? mode : 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!start) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          for (int l = 0; l < LANES; l++) begin
            data_d[8*(int'(base) + l) +: 8] = lane_out[l];
          end
          if (cnt_q == CNT_W'(C - 1)) begin
            out_d    = data_d;
            finish_d = 1'b1;
            busy_d   = 1'b0;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (!start) begin
          finish_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      out_q    <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      out_q    <= out_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign finish = finish_q;
  assign busy   = busy_q;
  assign out    = out_q;

endmodule

// File: tb/tb_aes_subbytes_lanes.sv
// Bench for aes_subbytes_lanes: one instance per legal LANES plus a forward-only
// instance, all driven together and checked against a GF(2^8)-derived S-box model.
module tb_aes_subbytes_lanes;

  localparam int NINST = 6;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         mode  = 1'b0;
  logic [127:0] in_s  = '0;
  logic [127:0] key_s = '0;

  logic         fin [NINST];
  logic         bsy [NINST];
  logic [127:0] res [NINST];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]   sbox_m [256];
  logic [7:0]   inv_m  [256];
  logic [127:0] last_exp [NINST];

  typedef struct {
    logic [127:0] din;
    logic [127:0] k;
    logic         m;
    logic [127:0] exp_out;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    aes_subbytes_lanes #(
      .LANES ((g < 5) ? (1 << g) : 4),
      .INV_EN((g < 5) ? 1 : 0)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .in    (in_s),
      .key   (key_s),
      .finish(fin[g]),
      .busy  (bsy[g]),
      .out   (res[g])
    );
  end

  function automatic int lanes_of(input int g);
    return (g < 5) ? (1 << g) : 4;
  endfunction

  function automatic int cycles_of(input int g);
    return 16 / lanes_of(g);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_model();
    logic [7:0] inv_x;
    for (int x = 0; x < 256; x++) begin
      inv_x = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv_x = 8'(y);
      end
      sbox_m[x] = inv_x ^ rotl(inv_x, 1) ^ rotl(inv_x, 2) ^ rotl(inv_x, 3) ^ rotl(inv_x, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_m[sbox_m[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_out(input logic [127:0] d, input logic [127:0] k, input logic m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (m) r[8*i +: 8] = inv_m[d[8*i +: 8]] ^ k[8*i +: 8];
      else   r[8*i +: 8] = sbox_m[d[8*i +: 8] ^ k[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] expect_for(input int g, input logic [127:0] d, input logic [127:0] k,
                                              input logic m);
    return ref_out(d, k, (g < 5) ? m : 1'b0);
  endfunction

  task automatic check_output(input string name, input int g, input logic [127:0] got, input logic [127:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s inst%0d (LANES=%0d): got %0h, required %0h", name, g, lanes_of(g), got, exp_v);
    end
  endtask

  // One full transaction on all instances, start held for 22 edges then dropped.
  task automatic apply_stimulus(input logic [127:0] d, input logic [127:0] k, input logic m,
                                input bit use_fixed, input logic [127:0] fixed_exp, input bit scramble);
    int           lat  [NINST];
    bit           bad  [NINST];
    logic [127:0] exp_v [NINST];
    @(negedge clk);
    in_s  = d;
    key_s = k;
    mode  = m;
    start = 1'b1;
    rst   = 1'b1;
    for (int g = 0; g < NINST; g++) begin
      exp_v[g] = (use_fixed && g < 5) ? fixed_exp : expect_for(g, d, k, m);
      lat[g]   = -1;
      bad[g]   = 1'b0;
    end
    for (int e = 0; e < 22; e++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NINST; g++) begin
        if (lat[g] < 0 && fin[g] === 1'b1) lat[g] = e;
        if (lat[g] < 0) begin
          if (bsy[g] !== 1'b1 || fin[g] !== 1'b0) bad[g] = 1'b1;
        end else if (fin[g] !== 1'b1 || bsy[g] !== 1'b0 || res[g] !== exp_v[g]) begin
          bad[g] = 1'b1;
        end
      end
      if (scramble) begin
        in_s  = {$urandom, $urandom, $urandom, $urandom};
        key_s = {$urandom, $urandom, $urandom, $urandom};
        mode  = 1'($urandom);
      end
    end
    for (int g = 0; g < NINST; g++) begin
      check_output("latency", g, 128'(lat[g]), 128'(cycles_of(g)));
      check_output("result", g, res[g], exp_v[g]);
      check_output("handshake_trace_bad", g, 128'(bad[g]), 128'(0));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < NINST; g++) begin
      check_output("finish_after_drop", g, 128'(fin[g]), 128'(0));
      check_output("out_retained", g, res[g], exp_v[g]);
      last_exp[g] = exp_v[g];
    end
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] rk;
    logic [127:0] r;
    logic [127:0] prior [NINST];
    logic [127:0] exp_new [NINST];
    bit           early [NINST];

    build_model();
    vecs[0] = '{128'h0, 128'h0, 1'b0, {16{8'h63}}};
    vecs[1] = '{128'h0, {16{8'h53}}, 1'b0, {16{8'hed}}};
    vecs[2] = '{{16{8'h63}}, 128'h0, 1'b1, 128'h0};
    vecs[3] = '{{16{8'h63}}, 128'h0102030405060708090a0b0c0d0e0f10, 1'b1, 128'h0102030405060708090a0b0c0d0e0f10};

    #2 rst = 1'b0;
    #1;
    for (int g = 0; g < NINST; g++) begin
      check_output("reset_finish", g, 128'(fin[g]), 128'(0));
      check_output("reset_busy", g, 128'(bsy[g]), 128'(0));
      check_output("reset_out", g, res[g], 128'h0);
    end

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(vecs[v].din, vecs[v].k, vecs[v].m, 1'b1, vecs[v].exp_out, 1'b1);
    end

    pt = 128'h6bc1bee22e409f96e93d7e117393172a;
    rk = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    apply_stimulus(pt, rk, 1'b0, 1'b0, 128'h0, 1'b1);
    r = ref_out(pt, rk, 1'b0);
    apply_stimulus(r, rk, 1'b1, 1'b1, pt, 1'b1);

    for (int n = 0; n < 8; n++) begin
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom), 1'b0, 128'h0, 1'b1);
    end

    // Abort: drop start after E0 plus five processing edges.
    @(negedge clk);
    in_s  = {$urandom, $urandom, $urandom, $urandom};
    key_s = {$urandom, $urandom, $urandom, $urandom};
    mode  = 1'b0;
    start = 1'b1;
    for (int g = 0; g < NINST; g++) begin
      prior[g]   = last_exp[g];
      exp_new[g] = expect_for(g, in_s, key_s, 1'b0);
      early[g]   = 1'b0;
    end
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NINST; g++) begin
        if (cycles_of(g) > 6 && fin[g] !== 1'b0) early[g] = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < NINST; g++) begin
      check_output("abort_finish_seen", g, 128'(early[g]), 128'(0));
      check_output("abort_finish", g, 128'(fin[g]), 128'(0));
      check_output("abort_busy", g, 128'(bsy[g]), 128'(0));
      if (cycles_of(g) > 6) check_output("abort_out_kept", g, res[g], prior[g]);
      else                  check_output("abort_short_out", g, res[g], exp_new[g]);
    end
    apply_stimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                   1'b0, 1'b0, 128'h0, 1'b1);

    // Asynchronous reset while parked in DONE, then restart with start already high.
    @(negedge clk);
    in_s  = {16{8'h5a}};
    key_s = {16{8'h3c}};
    mode  = 1'b0;
    start = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int g = 0; g < NINST; g++) begin
      check_output("async_reset_finish", g, 128'(fin[g]), 128'(0));
      check_output("async_reset_busy", g, 128'(bsy[g]), 128'(0));
      check_output("async_reset_out", g, res[g], 128'h0);
    end
    apply_stimulus({16{8'h11}}, {16{8'h22}}, 1'b1, 1'b0, 128'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/aes_subbytes_lanes.md
Name: aes_subbytes_lanes

Overview:
- Parametrised successor to the fixed single-mode AES SubBytes step.
- Applies AddRoundKey and SubBytes to a 128-bit AES state iteratively, LANES bytes per cycle, trading area for latency.
- Has a run-time forward/inverse mode, so one instance serves both the encrypt and decrypt round datapaths.
- Keeps the codebase's level-held start/finish handshake.

Parameters:
- LANES, 4: S-box lanes instantiated. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- INV_EN, 1: include inverse S-box lanes. When 0, inverse hardware is omitted and `mode` is ignored (always forward).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  level request; held high for the whole transaction.
- mode  input  1  0 = forward, 1 = inverse; sampled with start.
- in  input  128  state input; byte i = in[8i+7:8i].
- key  input  128  round key, same byte ordering.
- finish  output  1  result valid; held while start stays high.
- busy  output  1  high while in BUSY.
- out  output  128  result register.

Behaviour:
- Function, per byte i:
  - forward: out[i] = SBOX(in[i] ^ key[i]).
  - inverse: out[i] = INV_SBOX(in[i]) ^ key[i].
  - Consequence: inverse(forward(x,k),k) = x.
- Reset (rst low, async): state = IDLE, finish = 0, busy = 0, out = 0, byte counter = 0.
- C = 16/LANES cycles per operation.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On the first posedge with start = 1 (edge E0): latch in, key and mode into working registers; counter = 0; go to BUSY.
  - finish stays 0.
- BUSY:
  - Each posedge processes bytes [counter*LANES .. counter*LANES+LANES-1], LSB byte first, into the working register.
  - Counter increments by 1 per edge.
  - After the C-th processing edge (edge E0+C): copy the working result to `out`, set finish = 1, go to DONE.
  - busy = 1 from after E0 until after E0+C.
- DONE:
  - finish = 1 and `out` holds for as long as start = 1.
  - On the first posedge with start = 0: go to IDLE; finish = 0 after that edge.
  - `out` retains its value until the next completed operation.
- Latency: finish rises exactly C edges after the edge that sampled start (LANES=16 gives 1 cycle; LANES=1 gives 16).
- Input stability: in, key and mode may change freely after E0; the latched copies are used and changes mid-operation have no effect.
- Abort: start = 0 sampled in BUSY → IDLE on that edge.
  - finish never asserts.
  - `out` is NOT updated and keeps the previous result.
  - Counter returns to 0.
- Back-to-back operation: the requester must drop start for at least one edge. Start held high through DONE never re-triggers.
- Start = 1 at the same edge rst deasserts: IDLE samples start normally on that edge.
- Reset mid-operation: immediate return to reset values, including out = 0.
- S-boxes are combinational lookup tables (FIPS-197). They are shared across cycles and indexed by lane, not replicated 16 times unless LANES = 16.

Test Plan:
1. Forward, all-zero vectors: LANES=4, in = 0, key = 0, mode = 0 → out = 128'h63636363636363636363636363636363; finish first high exactly 4 edges after start is sampled.
2. Forward with key: in = 0, key = 128'h5353…53 (16 bytes), mode = 0 → out = 128'hedededededededededededededededed.
3. Inverse: in = 128'h6363…63, key = 0, mode = 1 → out = 0. Then key = 128'h0102030405060708090a0b0c0d0e0f10 → out equals key.
4. Round-trip: forward on in = 128'h6bc1bee22e409f96e93d7e117393172a, key = 128'h2b7e151628aed2a6abf7158809cf4f3c; feed the result back with mode = 1 and the same key → out equals the original in. Run for every legal LANES (1, 2, 4, 8, 16), checking latency 16/8/4/2/1 respectively.
5. Abort and stability: LANES=1, start dropped after 5 BUSY edges → finish never rises and out keeps the prior result. A new start then completes normally. Changing `in` during BUSY must not alter the result.
6. Reset and hold: assert rst low in DONE → finish = 0, out = 0 immediately (asynchronous). With no reset, hold start high for 10 cycles in DONE → finish and out stay constant and no retrigger occurs.
